// File: rtl/iob_axi_ram_resp.sv
// AXI4 INCR-burst responder backed by a dual-port word RAM.
// Write and read channels are served by independent FSMs and may overlap.
module iob_axi_ram_resp #(
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    cke_i,

    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,

    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,

    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,

    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,

    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);

    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int DEPTH  = 2 ** MEM_ADDR_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } r_state_t;

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_t              w_state_q, w_state_d;
    logic [AXI_ID_W-1:0]   w_id_q, w_id_d;
    logic [MEM_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [AXI_LEN_W-1:0]  w_len_q, w_len_d;
    logic [AXI_LEN_W-1:0]  w_cnt_q, w_cnt_d;
    logic                  w_err_q, w_err_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    r_state_t              r_state_q, r_state_d;
    logic [AXI_ID_W-1:0]   r_id_q, r_id_d;
    logic [MEM_ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [AXI_LEN_W-1:0]  r_len_q, r_len_d;
    logic [AXI_LEN_W-1:0]  r_cnt_q, r_cnt_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;

    // RAM
    logic [AXI_DATA_W-1:0] mem [DEPTH];
    logic [AXI_DATA_W-1:0] mem_rdata;
    logic                  mem_we;
    logic                  mem_re;

    // Handshakes only count on enabled clocks, so a frozen block never consumes a beat.
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_last_beat, w_beat_err, r_last_beat;

    assign aw_hs = cke_i & awready_q & axi_awvalid_i;
    assign w_hs  = cke_i & wready_q  & axi_wvalid_i;
    assign b_hs  = cke_i & bvalid_q  & axi_bready_i;
    assign ar_hs = cke_i & arready_q & axi_arvalid_i;
    assign r_hs  = cke_i & rvalid_q  & axi_rready_i;

    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_beat_err  = (axi_wlast_i != w_last_beat);
    assign r_last_beat = (r_cnt_q == r_len_q);

    // Only the word-index slice of the byte address is used; the rest aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_awaddr_i, axi_araddr_i};

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_id_d    = axi_awid_i;
                    w_addr_d  = axi_awaddr_i[MEM_ADDR_W+OFF-1:OFF];
                    w_len_d   = axi_awlen_i;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    mem_we   = 1'b1;
                    w_addr_d = w_addr_q + MEM_ADDR_W'(1);
                    if (w_last_beat) begin
                        bresp_d   = (w_err_q | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q + AXI_LEN_W'(1);
                        w_err_d = w_err_q | w_beat_err;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else if (cke_i) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        mem_re    = 1'b0;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_id_d    = axi_arid_i;
                    r_addr_d  = axi_araddr_i[MEM_ADDR_W+OFF-1:OFF];
                    r_len_d   = axi_arlen_i;
                    r_cnt_d   = '0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                mem_re    = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (r_hs) begin
                    if (r_last_beat) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d  = r_addr_q + MEM_ADDR_W'(1);
                        r_cnt_d   = r_cnt_q + AXI_LEN_W'(1);
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rlast_d   = rvalid_d && (r_cnt_d == r_len_d);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else if (cke_i) begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    // ------------------------------------------------------------------
    // Dual-port RAM: byte-masked write port, registered read port.
    // A same-cycle read of the word being written returns the old contents.
    // ------------------------------------------------------------------
    // NOTE: the array and its read register carry no reset; contents survive arst_n_i.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (mem_we) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (axi_wstrb_i[b]) begin
                        mem[w_addr_q][b*8 +: 8] <= axi_wdata_i[b*8 +: 8];
                    end
                end
            end
            if (mem_re) begin
                mem_rdata <= mem[r_addr_q];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign axi_awready_o = awready_q;
    assign axi_wready_o  = wready_q;
    assign axi_bid_o     = w_id_q;
    assign axi_bresp_o   = bresp_q;
    assign axi_bvalid_o  = bvalid_q;

    assign axi_arready_o = arready_q;
    assign axi_rid_o     = r_id_q;
    // Gated by rvalid so the un-reset read register never leaks onto the bus.
    assign axi_rdata_o   = rvalid_q ? mem_rdata : '0;
    assign axi_rresp_o   = RESP_OKAY;
    assign axi_rlast_o   = rlast_q;
    assign axi_rvalid_o  = rvalid_q;

endmodule
